mem_arbiter: RTL and testbench

Arbitrates the single 128×32 data/instruction RAM between two requesters: the instruction-fetch port (`if_`) and the memory-stage port (`mem_`). Each access is a request/grant/response transaction with a fixed, parameterised number of RAM wait cycles. `busy` is exported so the pipeline can stall. The block sits between the pipeline stages and the RAM; it owns the RAM's address, write-data and write-enable pins.

---
 rtl/oc2_mem_pkg.sv | 19 +
 rtl/mem_arb_pick.sv | 21 ++
 rtl/mem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oc2_mem_pkg.sv
// Shared types and defaults for the instruction/data RAM arbiter.
package oc2_mem_pkg;

    localparam int DEF_ADDR_W = 7;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_t;

    // Doubles as the bit index of each port in a one-hot grant vector.
    typedef enum logic {
        PORT_IF  = 1'b0,
        PORT_MEM = 1'b1
    } port_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between fetch and memory-stage requests.
// i_if_pri carries either the starvation flag or "memory won last" from the top.
module mem_arb_pick
    import oc2_mem_pkg::*;
(
    input  logic       i_if_req,
    input  logic       i_mem_req,
    input  logic       i_if_pri,
    output logic [1:0] o_gnt
);

    always_comb begin
        o_gnt = '0;
        if (i_if_req && (i_if_pri || !i_mem_req)) begin
            o_gnt[PORT_IF] = 1'b1;
        end else if (i_mem_req) begin
            o_gnt[PORT_MEM] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the shared 128x32 RAM between fetch (if_) and memory-stage (mem_) ports.
// Define MEM_ARB_RR_EN for round-robin; otherwise fixed mem priority with fetch starvation guard.
//
// state  | meaning
// IDLE   | no access in flight, requests sampled every edge
// ACCESS | RAM pins driven with the captured request for WAIT_CYCLES cycles
// RESP   | winner's rvalid pulses; requests sampled for a back-to-back access
module mem_arbiter
    import oc2_mem_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int WAIT_CYCLES  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_gnt,
    output logic              mem_rvalid,
    output logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wre,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    arb_state_t        r_state;
    port_t             r_port;
    logic [3:0]        r_cnt;
    logic              r_if_gnt;
    logic              r_if_rvalid;
    logic [DATA_W-1:0] r_if_rdata;
    logic              r_mem_gnt;
    logic              r_mem_rvalid;
    logic [DATA_W-1:0] r_mem_rdata;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_wdata;
    logic              r_ram_wre;
    logic              r_busy;

    logic [1:0]        w_pick;
    logic              w_any;
    logic              w_if_pri;
    port_t             w_win;

`ifdef MEM_ARB_RR_EN
    port_t             r_last;
    assign w_if_pri = (r_last == PORT_MEM);
`else
    logic [3:0]        r_starve;
    assign w_if_pri = (r_starve == 4'(STARVE_LIMIT));
`endif

    assign w_any = if_req | mem_req;
    assign w_win = w_pick[PORT_MEM] ? PORT_MEM : PORT_IF;

    mem_arb_pick u_pick (
        .i_if_req  (if_req),
        .i_mem_req (mem_req),
        .i_if_pri  (w_if_pri),
        .o_gnt     (w_pick)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_port       <= PORT_IF;
            r_cnt        <= '0;
            r_if_gnt     <= 1'b0;
            r_if_rvalid  <= 1'b0;
            r_if_rdata   <= '0;
            r_mem_gnt    <= 1'b0;
            r_mem_rvalid <= 1'b0;
            r_mem_rdata  <= '0;
            r_ram_addr   <= '0;
            r_ram_wdata  <= '0;
            r_ram_wre    <= 1'b0;
            r_busy       <= 1'b0;
`ifdef MEM_ARB_RR_EN
            r_last       <= PORT_IF;
`else
            r_starve     <= '0;
`endif
        end else begin
            r_if_gnt     <= 1'b0;
            r_mem_gnt    <= 1'b0;
            r_if_rvalid  <= 1'b0;
            r_mem_rvalid <= 1'b0;
            unique case (r_state)
                ST_IDLE, ST_RESP: begin
                    if (w_any) begin
                        r_state <= ST_ACCESS;
                        r_cnt   <= 4'(WAIT_CYCLES - 1);
                        r_port  <= w_win;
                        r_busy  <= 1'b1;
                        if (w_win == PORT_MEM) begin
                            r_mem_gnt   <= 1'b1;
                            r_ram_addr  <= mem_addr;
                            r_ram_wdata <= mem_wdata;
                            r_ram_wre   <= mem_we;
                        end else begin
                            r_if_gnt    <= 1'b1;
                            r_ram_addr  <= if_addr;
                            r_ram_wdata <= '0;
                            r_ram_wre   <= 1'b0;
                        end
`ifdef MEM_ARB_RR_EN
                        r_last <= w_win;
`else
                        if (if_req) begin
                            if (w_win == PORT_IF) begin
                                r_starve <= '0;
                            end else if (r_starve != 4'hF) begin
                                r_starve <= r_starve + 4'd1;
                            end
                        end
`endif
                    end else begin
                        r_state   <= ST_IDLE;
                        r_busy    <= 1'b0;
                        r_ram_wre <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        r_state   <= ST_RESP;
                        r_ram_wre <= 1'b0;
                        if (r_port == PORT_MEM) begin
                            r_mem_rvalid <= 1'b1;
                            // Writes leave the last read data visible.
                            if (!r_ram_wre) begin
                                r_mem_rdata <= ram_rdata;
                            end
                        end else begin
                            r_if_rvalid <= 1'b1;
                            r_if_rdata  <= ram_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign if_gnt     = r_if_gnt;
    assign if_rvalid  = r_if_rvalid;
    assign if_rdata   = r_if_rdata;
    assign mem_gnt    = r_mem_gnt;
    assign mem_rvalid = r_mem_rvalid;
    assign mem_rdata  = r_mem_rdata;
    assign ram_addr   = r_ram_addr;
    assign ram_wdata  = r_ram_wdata;
    assign ram_wre    = r_ram_wre;
    assign busy       = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with WAIT_CYCLES=1, one with WAIT_CYCLES=3.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [6:0]  if_addr = '0;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [6:0]  mem_addr = '0;
    logic [31:0] mem_wdata = '0;

    logic        w1_if_gnt, w1_if_rvalid, w1_mem_gnt, w1_mem_rvalid, w1_ram_wre, w1_busy;
    logic [31:0] w1_if_rdata, w1_mem_rdata, w1_ram_wdata, w1_ram_rdata;
    logic [6:0]  w1_ram_addr;
    logic        w3_if_gnt, w3_if_rvalid, w3_mem_gnt, w3_mem_rvalid, w3_ram_wre, w3_busy;
    logic [31:0] w3_if_rdata, w3_mem_rdata, w3_ram_wdata, w3_ram_rdata;
    logic [6:0]  w3_ram_addr;

    logic [31:0] ram [128];
    int checks = 0;
    int errors = 0;

    assign w1_ram_rdata = ram[w1_ram_addr];
    assign w3_ram_rdata = ram[w3_ram_addr];

    always #5 clock = ~clock;

    mem_arbiter #(.ADDR_W(7), .DATA_W(32), .WAIT_CYCLES(1), .STARVE_LIMIT(4)) u_w1 (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(w1_if_gnt),
        .if_rvalid(w1_if_rvalid), .if_rdata(w1_if_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(w1_mem_gnt), .mem_rvalid(w1_mem_rvalid), .mem_rdata(w1_mem_rdata),
        .ram_addr(w1_ram_addr), .ram_wdata(w1_ram_wdata), .ram_wre(w1_ram_wre),
        .ram_rdata(w1_ram_rdata), .busy(w1_busy)
    );

    mem_arbiter #(.ADDR_W(7), .DATA_W(32), .WAIT_CYCLES(3), .STARVE_LIMIT(4)) u_w3 (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(w3_if_gnt),
        .if_rvalid(w3_if_rvalid), .if_rdata(w3_if_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(w3_mem_gnt), .mem_rvalid(w3_mem_rvalid), .mem_rdata(w3_mem_rdata),
        .ram_addr(w3_ram_addr), .ram_wdata(w3_ram_wdata), .ram_wre(w3_ram_wre),
        .ram_rdata(w3_ram_rdata), .busy(w3_busy)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({w1_if_gnt, w1_if_rvalid, w1_mem_gnt, w1_mem_rvalid, w1_ram_wre, w1_busy} !== 6'b0) begin
            errors++;
            $display("FAIL reset_w1_ctrl got %b exp 000000",
                     {w1_if_gnt, w1_if_rvalid, w1_mem_gnt, w1_mem_rvalid, w1_ram_wre, w1_busy});
        end
        checks++;
        if ({w1_if_rdata, w1_mem_rdata, w1_ram_wdata, w1_ram_addr} !== 103'b0) begin
            errors++;
            $display("FAIL reset_w1_data got %h %h %h %h exp all 0",
                     w1_if_rdata, w1_mem_rdata, w1_ram_wdata, w1_ram_addr);
        end
        checks++;
        if ({w3_if_gnt, w3_if_rvalid, w3_mem_gnt, w3_mem_rvalid, w3_ram_wre, w3_busy,
             w3_if_rdata, w3_mem_rdata, w3_ram_wdata, w3_ram_addr} !== 109'b0) begin
            errors++;
            $display("FAIL reset_w3_outputs got nonzero exp all 0");
        end
    endtask

    task automatic test_mem_read();
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 7'h05;
        tick();
        checks++;
        if ({w1_mem_gnt, w1_if_gnt, w1_busy, w1_mem_rvalid} !== 4'b1010) begin
            errors++;
            $display("FAIL read_gnt got gnt=%b ifgnt=%b busy=%b rv=%b exp 1 0 1 0",
                     w1_mem_gnt, w1_if_gnt, w1_busy, w1_mem_rvalid);
        end
        checks++;
        if (w1_ram_addr !== 7'h05) begin
            errors++;
            $display("FAIL read_ram_addr got %h exp 05", w1_ram_addr);
        end
        mem_req = 1'b0;
        tick();
        checks++;
        if (w1_mem_rvalid !== 1'b1 || w1_mem_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL read_rvalid got rv=%b data=%h exp 1 deadbeef", w1_mem_rvalid, w1_mem_rdata);
        end
        tick();
        checks++;
        if (w1_busy !== 1'b0 || w1_mem_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL read_idle got busy=%b rv=%b exp 0 0", w1_busy, w1_mem_rvalid);
        end
        repeat (6) tick();
    endtask

    task automatic test_write();
        int wre_cnt = 0;
        int rv_cnt = 0;
        int bad_pins = 0;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 7'h10; mem_wdata = 32'h1234_5678;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (w3_ram_wre) begin
                wre_cnt++;
                if (w3_ram_addr !== 7'h10 || w3_ram_wdata !== 32'h1234_5678) bad_pins++;
            end
            if (w3_mem_rvalid) rv_cnt++;
            if (w3_mem_gnt) begin
                mem_req = 1'b0;
                mem_we = 1'b0;
            end
        end
        checks++;
        if (wre_cnt != 3) begin
            errors++;
            $display("FAIL write_wre_cycles got %0d exp 3", wre_cnt);
        end
        checks++;
        if (bad_pins != 0) begin
            errors++;
            $display("FAIL write_ram_pins got %0d bad cycles exp 0", bad_pins);
        end
        checks++;
        if (rv_cnt != 1) begin
            errors++;
            $display("FAIL write_rvalid_count got %0d exp 1", rv_cnt);
        end
        checks++;
        if (w3_mem_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL write_rdata_held got %h exp deadbeef", w3_mem_rdata);
        end
    endtask

    task automatic test_arbitration();
        logic [9:0] got = '0;
        logic [9:0] exp = '0;
        int n = 0;
        int both = 0;
        for (int i = 0; i < 10; i++) begin
`ifdef MEM_ARB_RR_EN
            exp[i] = (i % 2 == 0);
`else
            exp[i] = (i % 5 != 4);
`endif
        end
        do_reset();
        if_req = 1'b1; if_addr = 7'h40;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 7'h41;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (w1_if_gnt && w1_mem_gnt) both++;
            if ((w1_if_gnt || w1_mem_gnt) && n < 10) begin
                got[n] = w1_mem_gnt;
                n++;
            end
        end
        if_req = 1'b0; mem_req = 1'b0;
        checks++;
        if (n != 10) begin
            errors++;
            $display("FAIL arb_grant_count got %0d exp 10", n);
        end
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL arb_order got %b exp %b (bit0 first, 1=mem)", got, exp);
        end
        checks++;
        if (both != 0) begin
            errors++;
            $display("FAIL arb_double_gnt got %0d cycles exp 0", both);
        end
        repeat (8) tick();
    endtask

    task automatic test_reset_mid();
        int rv_cnt = 0;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 7'h22; mem_wdata = 32'hCAFE_F00D;
        tick();
        mem_req = 1'b0; mem_we = 1'b0;
        tick();
        checks++;
        if (w3_ram_wre !== 1'b1 || w3_busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_access2 got wre=%b busy=%b exp 1 1", w3_ram_wre, w3_busy);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({w3_if_gnt, w3_if_rvalid, w3_mem_gnt, w3_mem_rvalid, w3_ram_wre, w3_busy} !== 6'b0) begin
            errors++;
            $display("FAIL rstmid_ctrl got %b exp 000000",
                     {w3_if_gnt, w3_if_rvalid, w3_mem_gnt, w3_mem_rvalid, w3_ram_wre, w3_busy});
        end
        checks++;
        if ({w3_if_rdata, w3_mem_rdata, w3_ram_wdata, w3_ram_addr} !== 103'b0) begin
            errors++;
            $display("FAIL rstmid_data got %h %h %h %h exp all 0",
                     w3_if_rdata, w3_mem_rdata, w3_ram_wdata, w3_ram_addr);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            if (w3_mem_rvalid || w3_busy) rv_cnt++;
        end
        checks++;
        if (rv_cnt != 0) begin
            errors++;
            $display("FAIL rstmid_aborted got %0d active cycles exp 0", rv_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int rv = 0;
        int drop = 0;
        int bad_data = 0;
        int gcyc [3] = '{0, 0, 0};
        if_req = 1'b1; if_addr = 7'h00;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (n > 0 && rv < 3 && !w1_busy) drop++;
            if (w1_if_rvalid) begin
                if (w1_if_rdata !== (32'hC0DE_0000 + 32'(rv))) bad_data++;
                rv++;
            end
            if (w1_if_gnt && n < 3) begin
                gcyc[n] = c;
                n++;
                if (n < 3) if_addr = 7'(n);
                else if_req = 1'b0;
            end
        end
        if_req = 1'b0;
        checks++;
        if (n != 3 || rv != 3) begin
            errors++;
            $display("FAIL b2b_counts got gnt=%0d rvalid=%0d exp 3 3", n, rv);
        end
        checks++;
        if (gcyc[1] - gcyc[0] != 2 || gcyc[2] - gcyc[1] != 2) begin
            errors++;
            $display("FAIL b2b_spacing got %0d %0d exp 2 2", gcyc[1] - gcyc[0], gcyc[2] - gcyc[1]);
        end
        checks++;
        if (drop != 0) begin
            errors++;
            $display("FAIL b2b_busy got %0d low cycles exp 0", drop);
        end
        checks++;
        if (bad_data != 0) begin
            errors++;
            $display("FAIL b2b_rdata got %0d wrong words exp 0", bad_data);
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) ram[i] = 32'hC0DE_0000 + 32'(i);
        ram[5] = 32'hDEAD_BEEF;
        test_reset();
        test_mem_read();
        test_write();
        test_arbitration();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
